// File: rtl/pll_rst_ctrl.sv
// PLL lock qualification with staged system/peripheral reset release; PLL_RST_LOSS_CNT_EN adds a lock-loss counter.
// Latency: sys release LOCK_STABLE_CYC+2 edges after lock, periph PERIPH_DLY_CYC later, assertion 2 edges after drop; no backpressure.
module pll_rst_ctrl #(
    parameter int unsigned LOCK_STABLE_CYC = 1024,
    parameter int unsigned PERIPH_DLY_CYC  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       sys_rst_n,
    output logic       periph_rst_n,
    output logic       rst_done,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_STABLE = 2'd1,
        S_SYS    = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    localparam logic [15:0] LOCK_LAST   = 16'(LOCK_STABLE_CYC - 1);
    localparam logic [15:0] PERIPH_LAST = 16'(PERIPH_DLY_CYC - 1);

    logic        lock_m;
    logic        lock_s;
    state_t      state;
    state_t      state_nx;
    logic [15:0] cnt;
    logic [15:0] cnt_nx;

    // pll_lock comes from the PLL's own domain; only lock_s is used past here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    // A low lock_s is checked first so it overrides any terminal count
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_WAIT: begin
                cnt_nx = 16'd0;
                if (lock_s) begin
                    state_nx = S_STABLE;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_nx = S_WAIT;
                    cnt_nx   = 16'd0;
                end else if (cnt == LOCK_LAST) begin
                    state_nx = S_SYS;
                    cnt_nx   = 16'd0;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            S_SYS: begin
                if (!lock_s) begin
                    state_nx = S_WAIT;
                    cnt_nx   = 16'd0;
                end else if (cnt == PERIPH_LAST) begin
                    state_nx = S_RUN;
                    cnt_nx   = 16'd0;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_nx = S_WAIT;
                    cnt_nx   = 16'd0;
                end
            end
            default: begin
                state_nx = S_WAIT;
                cnt_nx   = 16'd0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_WAIT;
            cnt          <= 16'd0;
            sys_rst_n    <= 1'b0;
            periph_rst_n <= 1'b0;
            rst_done     <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            sys_rst_n    <= (state_nx == S_SYS) || (state_nx == S_RUN);
            periph_rst_n <= (state_nx == S_RUN);
            rst_done     <= (state_nx == S_RUN);
        end
    end

`ifdef PLL_RST_LOSS_CNT_EN
    logic       loss_event;
    logic [7:0] loss_q;

    assign loss_event = ((state == S_SYS) || (state == S_RUN)) && !lock_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loss_q <= 8'd0;
        end else if (loss_event && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign lock_loss_cnt = loss_q;
`else
    assign lock_loss_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Randomized lock patterns against a run-length reference model; scoreboard queue drained by a monitor.
module tb_pll_rst_ctrl;

    localparam int L = 8;
    localparam int P = 4;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       pll_lock = 1'b0;
    logic       sys_rst_n;
    logic       periph_rst_n;
    logic       rst_done;
    logic [7:0] lock_loss_cnt;

    typedef struct packed {
        logic       sys;
        logic       periph;
        logic       done;
        logic [7:0] lcnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // model state: length of the current run of high pll_lock samples, delayed two edges
    int   run_len;
    int   run_d1;
    int   run_d2;
    int   loss_events;
    logic prev_sys;

    pll_rst_ctrl #(
        .LOCK_STABLE_CYC(L),
        .PERIPH_DLY_CYC (P)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pll_lock     (pll_lock),
        .sys_rst_n    (sys_rst_n),
        .periph_rst_n (periph_rst_n),
        .rst_done     (rst_done),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        run_len     = 0;
        run_d1      = 0;
        run_d2      = 0;
        loss_events = 0;
        prev_sys    = 1'b0;
    endtask

    // sys needs L+1 consecutive high samples, periph L+P+1, both seen two edges later
    task automatic model_edge();
        exp_t e;
        int   r;
        logic s;
        if (reset) begin
            model_reset();
            e = '0;
        end else begin
            r       = run_d2;
            run_d2  = run_d1;
            run_len = pll_lock ? run_len + 1 : 0;
            run_d1  = run_len;
            s       = (r >= L + 1);
            if (prev_sys && !s) begin
                loss_events++;
            end
            prev_sys = s;
            e.sys    = s;
            e.periph = (r >= L + P + 1);
            e.done   = e.periph;
`ifdef PLL_RST_LOSS_CNT_EN
            e.lcnt   = (loss_events > 255) ? 8'd255 : 8'(loss_events);
`else
            e.lcnt   = 8'd0;
`endif
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic l);
        @(negedge clk);
        pll_lock = l;
        @(posedge clk);
        model_edge();
    endtask

    task automatic hold(input logic l, input int n);
        repeat (n) step(l);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1;
        exp_q.push_back('0);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        model_edge();
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0h exp %0h", name, $time, got, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk or posedge reset);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sys_rst_n", {7'd0, sys_rst_n}, {7'd0, e.sys});
                chk("periph_rst_n", {7'd0, periph_rst_n}, {7'd0, e.periph});
                chk("rst_done", {7'd0, rst_done}, {7'd0, e.done});
                chk("lock_loss_cnt", lock_loss_cnt, e.lcnt);
            end
        end
    end

    initial begin : driver
        model_reset();
        hold(1'b1, 3);
        #2;
        reset = 1'b0;
        hold(1'b1, 20);

        // single-cycle drop partway through the stable count
        hold(1'b0, 3);
        hold(1'b1, 8);
        hold(1'b0, 1);
        hold(1'b1, 20);

        // lock loss from run, then the full sequence again
        hold(1'b0, 3);
        hold(1'b1, 20);

        repeat (40) begin
            hold(1'b0, int'($urandom_range(1, 3)));
            hold(1'b1, int'($urandom_range(1, 20)));
        end

        // asynchronous reset while sys is released but periph is not
        hold(1'b0, 3);
        hold(1'b1, L + 5);
        pulse_reset();
        hold(1'b1, 20);

        hold(1'b0, 30);

        repeat (300) begin
            hold(1'b1, L + P + 4);
            hold(1'b0, 3);
        end
        hold(1'b1, 20);

        repeat (3) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
